// File: rtl/l2_arbiter.sv
// Two-requester arbiter sharing one L2 port between the L1 I-cache and L1 D-cache.
// Define L2ARB_DPRIO_EN for fixed D-side priority on ties; default build is round-robin.
module l2_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic              l2_ack,
    input  logic [DATA_W-1:0] l2_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic              own_d_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_any;
    logic              grant_d;
    logic              tie_to_d;

`ifdef L2ARB_DPRIO_EN
    assign tie_to_d = 1'b1;
`else
    // Remembers which side was latched last; reset value means "I served last".
    logic last_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (grant_any) begin
            last_d_q <= grant_d;
        end
    end

    assign tie_to_d = ~last_d_q;
`endif

    always_comb begin
        state_nxt = state_q;
        grant_any = 1'b0;
        grant_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_any = 1'b1;
                    grant_d   = d_req && (!i_req || tie_to_d);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Request latch and read-data capture; the I-side is read-only so its write fields are forced to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_d_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (grant_any) begin
                own_d_q <= grant_d;
                we_q    <= grant_d & d_we;
                addr_q  <= grant_d ? d_addr : i_addr;
                wdata_q <= grant_d ? d_wdata : '0;
            end
            if (state_q == ISSUE && l2_ack) begin
                rdata_q <= l2_rdata;
            end
        end
    end

    assign l2_req   = (state_q == ISSUE);
    assign l2_we    = we_q;
    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;
    assign i_ack    = (state_q == RESP) && !own_d_q;
    assign d_ack    = (state_q == RESP) && own_d_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed cases plus randomized traffic scored
// against a transaction-level model of the arbitration rule and handshake timing.
module tb_l2_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] rdata;
    logic              l2_req;
    logic              l2_we;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_wdata;
    logic              l2_ack;
    logic [DATA_W-1:0] l2_rdata;
    logic              busy;

    l2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .rdata    (rdata),
        .l2_req   (l2_req),
        .l2_we    (l2_we),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_ack   (l2_ack),
        .l2_rdata (l2_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pending requests as the requesters see them, and the fairness history.
    bit                m_i_pend;
    bit                m_d_pend;
    bit                m_d_we;
    bit                m_last_d;
    logic [ADDR_W-1:0] m_i_addr;
    logic [ADDR_W-1:0] m_d_addr;
    logic [DATA_W-1:0] m_d_wdata;
    logic [DATA_W-1:0] m_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic req_i(input logic [ADDR_W-1:0] a);
        m_i_pend = 1'b1;
        m_i_addr = a;
        i_req    = 1'b1;
        i_addr   = a;
    endtask

    task automatic req_d(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        m_d_pend  = 1'b1;
        m_d_we    = we;
        m_d_addr  = a;
        m_d_wdata = wd;
        d_req     = 1'b1;
        d_we      = we;
        d_addr    = a;
        d_wdata   = wd;
    endtask

    task automatic drop_all();
        m_i_pend = 1'b0;
        m_d_pend = 1'b0;
        i_req    = 1'b0;
        d_req    = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_l2_req"}, l2_req, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_acks"}, {i_ack, d_ack}, 2'b00);
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        l2_ack = 1'b0;
        drop_all();
        repeat (n) @(posedge clk);
        #1;
        rst      = 1'b0;
        m_last_d = 1'b0;
        m_rdata  = '0;
        chk_idle("reset");
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_l2_addr", l2_addr, 8'h0);
        chk("reset_l2_we", l2_we, 1'b0);
        chk("reset_l2_wdata", l2_wdata, 32'h0);
    endtask

    // Called at #1 into an IDLE cycle with at least one request pending; returns
    // at #1 into the following IDLE cycle. got_d reports which side was acked.
    task automatic do_txn(input int lat, input int rst_at, input logic [DATA_W-1:0] rd,
                          output bit got_d);
        bit                exp_d;
        bit                e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
`ifdef L2ARB_DPRIO_EN
        exp_d = m_d_pend;
`else
        exp_d = m_d_pend && (!m_i_pend || !m_last_d);
`endif
        e_we   = exp_d ? m_d_we : 1'b0;
        e_addr = exp_d ? m_d_addr : m_i_addr;
        e_wd   = exp_d ? m_d_wdata : 32'h0;
        got_d  = 1'b0;
        @(posedge clk);
        #1;
        m_last_d = exp_d;
        // Owner wiggles its inputs while still holding req; the latch must not follow.
        if (exp_d) begin
            d_addr  = ADDR_W'($urandom);
            d_wdata = $urandom;
            d_we    = 1'($urandom);
        end else begin
            i_addr = ADDR_W'($urandom);
        end
        for (int k = 1; k <= lat; k++) begin
            chk("issue_l2_req", l2_req, 1'b1);
            chk("issue_busy", busy, 1'b1);
            chk("issue_l2_we", l2_we, e_we);
            chk("issue_l2_addr", l2_addr, e_addr);
            chk("issue_l2_wdata", l2_wdata, e_wd);
            chk("issue_acks", {i_ack, d_ack}, 2'b00);
            if (k == rst_at) begin
                rst      = 1'b1;
                l2_ack   = 1'b1;
                l2_rdata = rd;
                @(posedge clk);
                #1;
                rst    = 1'b0;
                l2_ack = 1'b0;
                chk_idle("abort");
                chk("abort_rdata", rdata, 32'h0);
                chk("abort_l2_addr", l2_addr, 8'h0);
                chk("abort_l2_wdata", l2_wdata, 32'h0);
                drop_all();
                m_last_d = 1'b0;
                m_rdata  = '0;
                return;
            end
            if (k == lat) begin
                l2_ack   = 1'b1;
                l2_rdata = rd;
            end
            @(posedge clk);
            #1;
            l2_ack   = 1'b0;
            l2_rdata = $urandom;
        end
        chk("resp_i_ack", i_ack, !exp_d);
        chk("resp_d_ack", d_ack, exp_d);
        chk("resp_rdata", rdata, rd);
        chk("resp_l2_req", l2_req, 1'b0);
        chk("resp_busy", busy, 1'b1);
        got_d   = d_ack;
        m_rdata = rd;
        if (exp_d) begin
            m_d_pend = 1'b0;
            d_req    = 1'b0;
        end else begin
            m_i_pend = 1'b0;
            i_req    = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_idle("post");
    endtask

    // Idle cycles with no requests, optionally with spurious l2_ack pulses.
    task automatic idle(input int n, input bit spurious);
        for (int k = 0; k < n; k++) begin
            if (spurious) begin
                l2_ack   = 1'b1;
                l2_rdata = $urandom;
            end
            @(posedge clk);
            #1;
            l2_ack = 1'b0;
            chk_idle("idle");
            chk("idle_rdata", rdata, m_rdata);
        end
    endtask

    initial begin
        bit g;
        int lat;
        rst      = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_ack   = 1'b0;
        l2_rdata = '0;
        m_i_addr = '0;
        m_d_addr = '0;
        m_d_we   = 1'b0;
        m_d_wdata = '0;
        do_reset(3);

        // Single read, L2 acks in the first ISSUE cycle.
        req_d(1'b0, 8'h20, 32'h0);
        do_txn(1, 0, 32'h00ABCDEF, g);
        chk("rd_owner", g, 1'b1);

        // Write-through with four ISSUE cycles.
        req_d(1'b1, 8'h28, 32'h12345678);
        do_txn(4, 0, 32'h0BADF00D, g);
        chk("wr_owner", g, 1'b1);

        // Tie from reset release: D first, then I (or D again under fixed priority).
        do_reset(2);
        req_i(8'h18);
        req_d(1'b0, 8'h30, 32'h0);
        do_txn(2, 0, $urandom, g);
        chk("tie_first_d", g, 1'b1);
`ifdef L2ARB_DPRIO_EN
        req_d(1'b0, 8'h30, 32'h0);
        do_txn(1, 0, $urandom, g);
        chk("tie_prio_d_again", g, 1'b1);
        do_txn(1, 0, $urandom, g);
        chk("tie_prio_then_i", g, 1'b0);
`else
        do_txn(1, 0, $urandom, g);
        chk("tie_second_i", g, 1'b0);
`endif

        // Both sides held continuously for six transactions.
        do_reset(2);
        for (int t = 0; t < 6; t++) begin
            if (!m_i_pend) req_i(ADDR_W'($urandom));
            if (!m_d_pend) req_d(1'($urandom), ADDR_W'($urandom), $urandom);
            do_txn(int'($urandom_range(4, 1)), 0, $urandom, g);
`ifdef L2ARB_DPRIO_EN
            chk("both_held_prio", g, 1'b1);
`else
            chk("both_held_alt", g, (t % 2) == 0);
`endif
        end

        // Reset in ISSUE coinciding with l2_ack, then a normal transaction.
        drop_all();
        req_i(8'h44);
        do_txn(3, 2, 32'hDEADBEEF, g);
        req_i(8'h45);
        do_txn(1, 0, 32'h5A5A5A5A, g);
        chk("after_abort_i", g, 1'b0);

        // Spurious l2_ack while idle.
        idle(3, 1'b1);

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            if (!m_i_pend && $urandom_range(1, 0) == 1) req_i(ADDR_W'($urandom));
            if (!m_d_pend && $urandom_range(1, 0) == 1)
                req_d(1'($urandom), ADDR_W'($urandom), $urandom);
            if (!m_i_pend && !m_d_pend) begin
                idle(int'($urandom_range(3, 1)), 1'($urandom));
            end else begin
                lat = int'($urandom_range(4, 1));
                do_txn(lat, ($urandom_range(9, 0) == 0) ? int'($urandom_range(lat, 1)) : 0,
                       $urandom, g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
